// File: rtl/cg_rvarch_instr_decode.sv
// RV32/RV64 base-ISA instruction field and immediate decoder. The decoder is
// registered and backed by a 2-entry skid buffer so the upstream ready never depends on i_ready.
module cg_rvarch_instr_decode #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [6:0]             o_opcode,
    output logic [4:0]             o_rd,
    output logic [2:0]             o_funct3,
    output logic [4:0]             o_rs1,
    output logic [4:0]             o_rs2,
    output logic [6:0]             o_funct7,
    output logic [2:0]             o_fmt,
    output logic [XLEN-1:0]        o_imm,
    output logic                   o_illegal
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        fmt_e            fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } dec_t;

    dec_t        dec;
    logic [31:0] imm32;
    logic [31:0] instr;

    assign instr = i_instr[31:0];

    always_comb begin
        dec         = '0;
        dec.opcode  = instr[6:0];
        dec.rd      = instr[11:7];
        dec.funct3  = instr[14:12];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct7  = instr[31:25];
        dec.fmt     = FMT_ILL;
        imm32       = '0;
        if (instr[1:0] == 2'b11) begin
            unique case (instr[6:0])
                7'b0000011, 7'b0001111, 7'b0010011,
                7'b1100111, 7'b1110011: dec.fmt = FMT_I;
                7'b0100011:             dec.fmt = FMT_S;
                7'b1100011:             dec.fmt = FMT_B;
                7'b0110111, 7'b0010111: dec.fmt = FMT_U;
                7'b1101111:             dec.fmt = FMT_J;
                7'b0110011:             dec.fmt = FMT_R;
                7'b0011011:             dec.fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
                7'b0111011:             dec.fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
                default:                dec.fmt = FMT_ILL;
            endcase
        end
        unique case (dec.fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        dec.imm     = XLEN'($signed(imm32));
        dec.illegal = (dec.fmt == FMT_ILL);
    end

    state_e state_q, state_d;
    dec_t   out_q, out_d;
    dec_t   skid_q, skid_d;
    logic   accept, drain;

    assign o_ready = (state_q != TWO);
    assign o_valid = (state_q != EMPTY);
    assign accept  = i_valid && o_ready;
    assign drain   = o_valid && i_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_d   = dec;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    out_d = dec;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = TWO;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // o_ready is low here, so only a drain can happen
                if (drain) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign o_opcode  = out_q.opcode;
    assign o_rd      = out_q.rd;
    assign o_funct3  = out_q.funct3;
    assign o_rs1     = out_q.rs1;
    assign o_rs2     = out_q.rs2;
    assign o_funct7  = out_q.funct7;
    assign o_fmt     = out_q.fmt;
    assign o_imm     = out_q.imm;
    assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_cg_rvarch_instr_decode.sv
// Directed-vector bench: an XLEN=32 and an XLEN=64 decoder share all inputs.
module tb_cg_rvarch_instr_decode;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [31:0] instr;

    logic        rdy32, vld32, ill32;
    logic [6:0]  opc32, f7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  f3_32, fmt32;
    logic [31:0] imm32;

    logic        rdy64, vld64, ill64;
    logic [6:0]  opc64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64, fmt64;
    logic [63:0] imm64;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    cg_rvarch_instr_decode #(.XLEN(32), .INSTR_WIDTH(32)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy32),
        .i_instr(instr), .o_valid(vld32), .i_ready(ready),
        .o_opcode(opc32), .o_rd(rd32), .o_funct3(f3_32), .o_rs1(rs1_32),
        .o_rs2(rs2_32), .o_funct7(f7_32), .o_fmt(fmt32), .o_imm(imm32),
        .o_illegal(ill32)
    );

    cg_rvarch_instr_decode #(.XLEN(64), .INSTR_WIDTH(32)) u_dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy64),
        .i_instr(instr), .o_valid(vld64), .i_ready(ready),
        .o_opcode(opc64), .o_rd(rd64), .o_funct3(f3_64), .o_rs1(rs1_64),
        .o_rs2(rs2_64), .o_funct7(f7_64), .o_fmt(fmt64), .o_imm(imm64),
        .o_illegal(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present one word with i_ready=1, then check both decoders one cycle later.
    task automatic decode_check(input logic [31:0] w,
                                input logic [2:0] e_fmt32, input logic [31:0] e_imm32,
                                input logic [2:0] e_fmt64, input logic [63:0] e_imm64);
        logic [31:0] v;
        v     = w;
        valid = 1'b1;
        ready = 1'b1;
        instr = w;
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("valid32", 64'(vld32), 64'd1);
        check("opcode", 64'(opc32), 64'(v[6:0]));
        check("rd", 64'(rd32), 64'(v[11:7]));
        check("funct3", 64'(f3_32), 64'(v[14:12]));
        check("rs1", 64'(rs1_32), 64'(v[19:15]));
        check("rs2", 64'(rs2_32), 64'(v[24:20]));
        check("funct7", 64'(f7_32), 64'(v[31:25]));
        check("fmt32", 64'(fmt32), 64'(e_fmt32));
        check("imm32", 64'(imm32), 64'(e_imm32));
        check("ill32", 64'(ill32), 64'(e_fmt32 == 3'd7));
        check("valid64", 64'(vld64), 64'd1);
        check("fmt64", 64'(fmt64), 64'(e_fmt64));
        check("imm64", imm64, e_imm64);
        check("ill64", 64'(ill64), 64'(e_fmt64 == 3'd7));
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        ready = 1'b0;
        instr = '0;
        #3;
        check("rst_valid", 64'(vld32), 64'd0);
        check("rst_ready", 64'(rdy32), 64'd1);
        check("rst_fmt", 64'(fmt32), 64'd0);
        check("rst_imm", imm64, 64'd0);
        check("rst_rd", 64'(rd32), 64'd0);
        check("rst_ill", 64'(ill32), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        decode_check(32'hFFF00093, 3'd1, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFF_FFFFFFFF);
        decode_check(32'h123452B7, 3'd4, 32'h12345000, 3'd4, 64'h00000000_12345000);
        decode_check(32'h800002B7, 3'd4, 32'h80000000, 3'd4, 64'hFFFFFFFF_80000000);
        decode_check(32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 3'd5, 64'hFFFFFFFF_FFFFFFFC);
        decode_check(32'hFE000CE3, 3'd3, 32'hFFFFFFF8, 3'd3, 64'hFFFFFFFF_FFFFFFF8);
        decode_check(32'h00112423, 3'd2, 32'h00000008, 3'd2, 64'h00000000_00000008);
        decode_check(32'h002081B3, 3'd0, 32'h00000000, 3'd0, 64'h0);
        decode_check(32'h0000003B, 3'd7, 32'h00000000, 3'd0, 64'h0);
        decode_check(32'hFFF0009B, 3'd7, 32'h00000000, 3'd1, 64'hFFFFFFFF_FFFFFFFF);
        decode_check(32'hFFF00090, 3'd7, 32'h00000000, 3'd7, 64'h0);
        decode_check(32'h0000007F, 3'd7, 32'h00000000, 3'd7, 64'h0);

        // drain the last result
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("drained", 64'(vld32), 64'd0);

        // Back-pressure: three back-to-back words with i_ready=0
        ready = 1'b0;
        valid = 1'b1;
        instr = 32'h00100093;
        @(posedge clk);
        #1;
        check("bp1_valid", 64'(vld32), 64'd1);
        check("bp1_ready", 64'(rdy32), 64'd1);
        check("bp1_imm", 64'(imm32), 64'd1);
        instr = 32'h00200113;
        @(posedge clk);
        #1;
        check("bp2_ready", 64'(rdy32), 64'd0);
        check("bp2_imm", 64'(imm32), 64'd1);
        instr = 32'h00300193;
        @(posedge clk);
        #1;
        check("bp3_ready", 64'(rdy32), 64'd0);
        check("bp3_hold_imm", 64'(imm32), 64'd1);
        check("bp3_hold_rd", 64'(rd32), 64'd1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("dr1_imm", 64'(imm32), 64'd2);
        check("dr1_rd", 64'(rd32), 64'd2);
        check("dr1_ready", 64'(rdy32), 64'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("dr2_imm", 64'(imm32), 64'd3);
        check("dr2_valid", 64'(vld32), 64'd1);
        @(posedge clk);
        #1;
        check("dr3_valid", 64'(vld32), 64'd0);

        // Asynchronous reset while two results are buffered
        ready = 1'b0;
        valid = 1'b1;
        instr = 32'h00100093;
        @(posedge clk);
        #1;
        instr = 32'h00200113;
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("two_ready", 64'(rdy32), 64'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(vld32), 64'd0);
        check("arst_ready", 64'(rdy32), 64'd1);
        check("arst_imm", 64'(imm32), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", 64'(vld32), 64'd0);
        end
        decode_check(32'h123452B7, 3'd4, 32'h12345000, 3'd4, 64'h00000000_12345000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
